// File: rtl/uart_to_reg_pkg.sv
// Shared types and helpers for the UART-to-LED register unit.
package uart_to_reg_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizers, mid-bit sampling FSM and LSB-first shift register.
module uart_rx_core
    import uart_to_reg_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9_600,
    parameter int WORDSZ   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              sw,
    output logic [WORDSZ-1:0] rx_byte,
    output logic              rx_valid
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W        = $clog2(WORDSZ) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORDSZ - 1);

    logic rxd_p0, rxd_p1, sw_p0, sw_p1;
    uart_state_t state, state_n;
    logic [CNT_W-1:0] baud_cnt, cnt_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic armed, armed_n;
    logic frame_err, ferr_n;
    logic valid_n, sample_bit;
    logic [WORDSZ-1:0] shreg;

    // Stage p0/p1: two-flop synchronizers, idle-high on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            sw_p0  <= 1'b1;
            sw_p1  <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            armed     <= 1'b0;
            frame_err <= 1'b0;
            rx_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= cnt_n;
            bit_cnt   <= bit_n;
            armed     <= armed_n;
            frame_err <= ferr_n;
            rx_valid  <= valid_n;
        end
    end

    // armed: the line has been seen high in IDLE, so a falling edge is a real start bit
    always_comb begin
        state_n    = state;
        cnt_n      = baud_cnt + CNT_W'(1);
        bit_n      = bit_cnt;
        armed_n    = armed;
        ferr_n     = frame_err;
        valid_n    = 1'b0;
        sample_bit = 1'b0;
        if (!sw_p1) begin
            state_n = IDLE;
            cnt_n   = '0;
            bit_n   = '0;
            armed_n = 1'b0;
            ferr_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (rxd_p1) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n = START;
                        bit_n   = '0;
                        armed_n = 1'b0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_M1) begin
                        cnt_n   = '0;
                        state_n = rxd_p1 ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_M1) begin
                        cnt_n      = '0;
                        sample_bit = 1'b1;
                        bit_n      = bit_cnt + BIT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state_n = STOP;
                            bit_n   = '0;
                        end
                    end
                end
                STOP: begin
                    if (frame_err) begin
                        cnt_n = '0;
                        if (rxd_p1) begin
                            state_n = IDLE;
                            ferr_n  = 1'b0;
                        end
                    end else if (baud_cnt == FULL_M1) begin
                        cnt_n = '0;
                        if (rxd_p1) begin
                            state_n = IDLE;
                            valid_n = 1'b1;
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Right shift: after WORDSZ samples the first bit received sits in bit 0
    always_ff @(posedge clk) begin
        if (sample_bit) shreg <= {rxd_p1, shreg[WORDSZ-1:1]};
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/uart_to_reg_unit.sv
// UART receiver driving an LED register, with each accepted byte echoed on TXD_PIN.
module uart_to_reg_unit
    import uart_to_reg_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9_600,
    parameter int WORDSZ   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RXD_PIN,
    output logic              TXD_PIN,
    input  logic              SW_0,
    output logic [WORDSZ-1:0] LED
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W        = $clog2(WORDSZ) + 1;
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORDSZ - 1);

    logic [WORDSZ-1:0] rx_byte;
    logic              rx_valid;
    uart_state_t       tx_state, tx_state_n;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_n;
    logic [BIT_W-1:0]  tx_bit, tx_bit_n;
    logic              txd_n, tx_load, tx_shift;
    logic [WORDSZ-1:0] tx_shreg;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .WORDSZ   (WORDSZ)
    ) u_rx (
        .clk      (CLK),
        .rst      (RST),
        .rxd      (RXD_PIN),
        .sw       (SW_0),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) LED <= '0;
        else if (rx_valid) LED <= rx_byte;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            TXD_PIN  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            TXD_PIN  <= txd_n;
        end
    end

    // The last stop-bit cycle also accepts a new byte so back-to-back frames echo without loss
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CNT_W'(1);
        tx_bit_n   = tx_bit;
        txd_n      = TXD_PIN;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
                if (rx_valid) begin
                    tx_state_n = START;
                    tx_load    = 1'b1;
                    txd_n      = 1'b0;
                end
            end
            START: begin
                if (tx_cnt == FULL_M1) begin
                    tx_cnt_n   = '0;
                    tx_state_n = DATA;
                    tx_bit_n   = '0;
                    txd_n      = tx_shreg[0];
                end
            end
            DATA: begin
                if (tx_cnt == FULL_M1) begin
                    tx_cnt_n = '0;
                    tx_shift = 1'b1;
                    tx_bit_n = tx_bit + BIT_W'(1);
                    txd_n    = tx_shreg[1];
                    if (tx_bit == LAST_BIT) begin
                        tx_state_n = STOP;
                        tx_bit_n   = '0;
                        txd_n      = 1'b1;
                    end
                end
            end
            STOP: begin
                if (tx_cnt == FULL_M1) begin
                    tx_cnt_n = '0;
                    if (rx_valid) begin
                        tx_state_n = START;
                        tx_load    = 1'b1;
                        txd_n      = 1'b0;
                    end else begin
                        tx_state_n = IDLE;
                    end
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (tx_load) tx_shreg <= rx_byte;
        else if (tx_shift) tx_shreg <= {1'b0, tx_shreg[WORDSZ-1:1]};
    end

endmodule

// File: tb/tb_uart_to_reg_unit.sv
// Directed bench for uart_to_reg_unit at a reduced bit period of 16 clocks.
module tb_uart_to_reg_unit;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic       CLK;
    logic       RST;
    logic       RXD_PIN;
    logic       TXD_PIN;
    logic       SW_0;
    logic [7:0] LED;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] data;
        logic       ok;
    } echo_t;
    echo_t echo_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       sw;
        logic [7:0] exp_led;
        int         exp_echo;
    } vec_t;
    vec_t vecs[9];

    uart_to_reg_unit #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .WORDSZ   (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .RXD_PIN (RXD_PIN),
        .TXD_PIN (TXD_PIN),
        .SW_0    (SW_0),
        .LED     (LED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            @(negedge CLK);
            RXD_PIN = f[b];
            repeat (CPB - 1) @(negedge CLK);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Decodes each frame on TXD_PIN; each bit must hold near its start, middle and end
    initial begin : tx_monitor
        logic [9:0] bits;
        logic       consistent;
        logic       v;
        forever begin
            @(negedge CLK);
            if (TXD_PIN === 1'b0 && RST === 1'b0) begin
                consistent = 1'b1;
                bits       = '0;
                v          = 1'b0;
                for (int o = 0; o < 10 * CPB; o++) begin
                    if (o != 0) @(negedge CLK);
                    if (o % CPB == 1) begin
                        v = TXD_PIN;
                    end else if (o % CPB == CPB / 2) begin
                        bits[o / CPB] = TXD_PIN;
                        if (TXD_PIN !== v) consistent = 1'b0;
                    end else if (o % CPB == CPB - 2) begin
                        if (TXD_PIN !== v) consistent = 1'b0;
                    end
                end
                echo_q.push_back('{data: bits[8:1],
                                   ok: consistent && bits[0] == 1'b0 && bits[9] == 1'b1});
            end
        end
    end

    initial begin : main
        int cnt;

        vecs[0] = '{data: 8'h41, stop: 1'b1, sw: 1'b1, exp_led: 8'h41, exp_echo: 1};
        vecs[1] = '{data: 8'h00, stop: 1'b1, sw: 1'b1, exp_led: 8'h00, exp_echo: 1};
        vecs[2] = '{data: 8'h5A, stop: 1'b1, sw: 1'b0, exp_led: 8'h00, exp_echo: 0};
        vecs[3] = '{data: 8'hC3, stop: 1'b1, sw: 1'b1, exp_led: 8'hC3, exp_echo: 1};
        vecs[4] = '{data: 8'hA5, stop: 1'b0, sw: 1'b1, exp_led: 8'hC3, exp_echo: 0};
        vecs[5] = '{data: 8'h3C, stop: 1'b1, sw: 1'b1, exp_led: 8'h3C, exp_echo: 1};
        vecs[6] = '{data: 8'hFF, stop: 1'b1, sw: 1'b1, exp_led: 8'hFF, exp_echo: 1};
        vecs[7] = '{data: 8'h80, stop: 1'b1, sw: 1'b1, exp_led: 8'h80, exp_echo: 1};
        vecs[8] = '{data: 8'h01, stop: 1'b1, sw: 1'b1, exp_led: 8'h01, exp_echo: 1};

        RST     = 1'b1;
        RXD_PIN = 1'b1;
        SW_0    = 1'b1;

        // Reset
        idle(2);
        check("rst_led_during", LED, 8'h00);
        check("rst_txd_during", TXD_PIN, 1'b1);
        idle(3);
        RST = 1'b0;
        idle(2 * CPB);
        check("rst_led_after", LED, 8'h00);
        check("rst_txd_after", TXD_PIN, 1'b1);

        // Single 0x41 frame: latency and echo bit pattern
        echo_q.delete();
        cnt = 0;
        fork
            send_frame(8'h41, 1'b1);
            begin
                while (LED !== 8'h41 && cnt < 10 * CPB) begin
                    @(negedge CLK);
                    cnt++;
                end
            end
        join
        check("a_latency_in_range", (cnt >= 9 * CPB && cnt <= 9 * CPB + CPB / 2 + 8), 1'b1);
        check("a_led", LED, 8'h41);
        idle(11 * CPB);
        check("a_echo_count", echo_q.size(), 1);
        if (echo_q.size() == 1) begin
            check("a_echo_data", echo_q[0].data, 8'h41);
            check("a_echo_framing", echo_q[0].ok, 1'b1);
        end

        // Back-to-back 0x41, 0x00
        idle(2 * CPB);
        echo_q.delete();
        send_frame(8'h41, 1'b1);
        check("b2b_led_first", LED, 8'h41);
        send_frame(8'h00, 1'b1);
        idle(12 * CPB);
        check("b2b_led_second", LED, 8'h00);
        check("b2b_echo_count", echo_q.size(), 2);
        if (echo_q.size() == 2) begin
            check("b2b_echo0_data", echo_q[0].data, 8'h41);
            check("b2b_echo1_data", echo_q[1].data, 8'h00);
            check("b2b_echo_framing", echo_q[0].ok && echo_q[1].ok, 1'b1);
        end

        // Framing error, line held low, then a good frame
        idle(2 * CPB);
        echo_q.delete();
        send_frame(8'hA5, 1'b0);
        idle(3 * CPB);
        RXD_PIN = 1'b1;
        idle(12 * CPB);
        check("ferr_led_unchanged", LED, 8'h00);
        check("ferr_no_echo", echo_q.size(), 0);
        send_frame(8'h3C, 1'b1);
        idle(12 * CPB);
        check("ferr_next_led", LED, 8'h3C);
        check("ferr_next_echo_count", echo_q.size(), 1);
        if (echo_q.size() == 1) check("ferr_next_echo_data", echo_q[0].data, 8'h3C);

        // Enable rises in the middle of a frame: frame must be ignored
        SW_0 = 1'b0;
        idle(2 * CPB);
        echo_q.delete();
        fork
            send_frame(8'h00, 1'b1);
            begin
                idle(4 * CPB);
                SW_0 = 1'b1;
            end
        join
        idle(12 * CPB);
        check("swrise_led_unchanged", LED, 8'h3C);
        check("swrise_no_echo", echo_q.size(), 0);

        // Short low glitch on the line
        echo_q.delete();
        @(negedge CLK);
        RXD_PIN = 1'b0;
        idle(3);
        RXD_PIN = 1'b1;
        idle(12 * CPB);
        check("glitch_led_unchanged", LED, 8'h3C);
        check("glitch_no_echo", echo_q.size(), 0);

        // Table of single frames
        for (int i = 0; i < 9; i++) begin
            SW_0 = vecs[i].sw;
            idle(4);
            echo_q.delete();
            send_frame(vecs[i].data, vecs[i].stop);
            @(negedge CLK);
            RXD_PIN = 1'b1;
            idle(12 * CPB);
            check($sformatf("vec%0d_led", i), LED, vecs[i].exp_led);
            check($sformatf("vec%0d_echo_count", i), echo_q.size(), vecs[i].exp_echo);
            if (vecs[i].exp_echo == 1 && echo_q.size() == 1) begin
                check($sformatf("vec%0d_echo_data", i), echo_q[0].data, vecs[i].data);
                check($sformatf("vec%0d_echo_framing", i), echo_q[0].ok, 1'b1);
            end
            SW_0 = 1'b1;
            idle(2 * CPB);
        end

        // Reset asserted mid-frame while the previous echo is still on the wire
        echo_q.delete();
        send_frame(8'h0F, 1'b1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(6 * CPB + 8);
                check("midrst_led_before", LED, 8'h0F);
                check("midrst_txd_before", TXD_PIN, 1'b0);
                #2 RST = 1'b1;
                #1;
                check("midrst_txd_async", TXD_PIN, 1'b1);
                check("midrst_led_async", LED, 8'h00);
                idle(3);
                RST = 1'b0;
            end
        join
        idle(4 * CPB);
        echo_q.delete();
        idle(12 * CPB);
        check("midrst_led_after", LED, 8'h00);
        check("midrst_no_echo", echo_q.size(), 0);
        check("midrst_txd_idle", TXD_PIN, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
